jedro_1_dmem_resp: RTL
======================

JEDRO_1_DMEM_RESP -- requirements
Module: jedro_1_dmem_resp

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-002 Parameter MEM_WORDS, default 1024, number of 32-bit words; SHALL be a power of two.
REQ-003 Parameter LATENCY, default 1, wait cycles from request accept to response, range 0..7.
REQ-004 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 req_valid_i  in  1  LSU request valid.
REQ-007 req_ready_o  out  1  responder can accept a request.
REQ-008 req_we_i  in  1  1 = store, 0 = load.
REQ-009 req_be_i  in  4  byte enables, bit n selects byte lane n.
REQ-010 req_addr_i  in  32  byte address.
REQ-011 req_wdata_i  in  32  store data, lane-aligned.
REQ-012 rsp_valid_o  out  1  response valid.
REQ-013 rsp_ready_i  in  1  LSU accepts the response.
REQ-014 rsp_rdata_o  out  32  load data, lane-aligned, unselected lanes zero.
REQ-015 rsp_err_o  out  1  access fault, valid with rsp_valid_o.

Function
REQ-016 States: IDLE, WAIT, RESP; one outstanding transaction only.
REQ-017 req_ready_o SHALL be 1 exactly in IDLE; a request is accepted when req_valid_i && req_ready_o.
REQ-018 On accept: LATENCY=0 -> RESP next cycle; else WAIT with counter loaded to LATENCY-1.
REQ-019 WAIT decrements each cycle; at count 0, next cycle is RESP.
REQ-020 RESP holds rsp_valid_o=1 and stable rsp_rdata_o/rsp_err_o until rsp_ready_i=1; then IDLE next cycle.
REQ-021 No new request accepted in the cycle a response completes (minimum 1 IDLE cycle between transactions).
REQ-022 Legal be: 4'b0001/0010/0100/1000 (any addr[1:0] matching lane), 4'b0011 with addr[1:0]=0, 4'b1100 with addr[1:0]=2, 4'b1111 with addr[1:0]=0.
REQ-023 Error when be illegal, be/addr[1:0] mismatch, or addr outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS).
REQ-024 Legal store: enabled lanes written at word index (addr-BASE_ADDR)>>2 on the accept edge; disabled lanes unchanged.
REQ-025 Erroneous store: memory unchanged, rsp_err_o=1, rsp_rdata_o=0.
REQ-026 Legal load: word read on the accept edge, registered; rsp_rdata_o = word masked by be; erroneous load returns 0 with rsp_err_o=1.
REQ-027 Store response: rsp_rdata_o=0.
REQ-028 Inputs other than rsp_ready_i are ignored outside the accept cycle.

Reset
REQ-029 rst_i=1 SHALL force IDLE, counter 0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, req_ready_o=0 during reset.
REQ-030 req_ready_o SHALL be 1 in the first cycle after rst_i deasserts.
REQ-031 Reset mid-transaction SHALL drop it without a response; a store already accepted stays written.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-033 Shared package SHALL hold typedef dmem_state_e {IDLE, WAIT, RESP} and localparams DMEM_BE_BYTE0..3, DMEM_BE_HALF0, DMEM_BE_HALF1, DMEM_BE_WORD.
REQ-034 Storage SHALL be sub-module jedro_1_dmem_ram (byte-enabled write, registered read, parameter MEM_WORDS); FSM, legality check, masking stay in jedro_1_dmem_resp.

Verification
REQ-035 Store 32'hDEADBEEF be=1111 @8000_0010, then load be=1111 -> rdata 32'hDEADBEEF, err 0, rsp_valid 2 cycles after each accept (LATENCY=1).
REQ-036 Store 32'h0000_AB00 be=0010 @8000_0011 over DEADBEEF, load be=1111 @8000_0010 -> 32'hDEADABEF.
REQ-037 Load be=0011 @8000_0012 -> err 1, rdata 0; load be=1111 @8000_1000 (MEM_WORDS=1024) -> err 1; store there leaves memory unchanged.
REQ-038 Hold rsp_ready_i=0 5 cycles in RESP -> rsp_valid_o and rdata stable, req_ready_o=0; release -> IDLE next cycle.
REQ-039 LATENCY=0 and LATENCY=7: rsp_valid_o asserted 1 and 8 cycles after accept respectively.
REQ-040 Assert rst_i during WAIT of a store -> no response, outputs 0, subsequent load returns stored data.

Source files
------------

// File: rtl/jedro_1_dmem_resp_pkg.sv
// Shared types and constants for the jedro_1 data-memory responder.
package jedro_1_dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] DMEM_BE_BYTE0 = 4'b0001;
  localparam logic [3:0] DMEM_BE_BYTE1 = 4'b0010;
  localparam logic [3:0] DMEM_BE_BYTE2 = 4'b0100;
  localparam logic [3:0] DMEM_BE_BYTE3 = 4'b1000;
  localparam logic [3:0] DMEM_BE_HALF0 = 4'b0011;
  localparam logic [3:0] DMEM_BE_HALF1 = 4'b1100;
  localparam logic [3:0] DMEM_BE_WORD  = 4'b1111;

  // A byte-enable pattern is legal only in its natural alignment.
  function automatic logic be_addr_legal(input logic [3:0] be, input logic [1:0] lo);
    logic ok;
    case (be)
      DMEM_BE_BYTE0: ok = (lo == 2'd0);
      DMEM_BE_BYTE1: ok = (lo == 2'd1);
      DMEM_BE_BYTE2: ok = (lo == 2'd2);
      DMEM_BE_BYTE3: ok = (lo == 2'd3);
      DMEM_BE_HALF0: ok = (lo == 2'd0);
      DMEM_BE_HALF1: ok = (lo == 2'd2);
      DMEM_BE_WORD:  ok = (lo == 2'd0);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Expand byte enables into a 32-bit lane mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/jedro_1_dmem_ram.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module jedro_1_dmem_ram #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic                         re_i,
  input  logic [3:0]                   be_i,
  input  logic [$clog2(MEM_WORDS)-1:0] addr_i,
  input  logic [31:0]                  wdata_i,
  output logic [31:0]                  rdata_o
);

  logic [31:0] mem [MEM_WORDS];

  // Byte-lane writes and read-data capture; the read register holds between reads.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/jedro_1_dmem_resp.sv
// Single-outstanding data-memory responder for the jedro_1 LSU.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the request side is ready only in IDLE, and a response stays valid with stable
// data/err until the LSU raises rsp_ready_i.
module jedro_1_dmem_resp
  import jedro_1_dmem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [2:0]  LAT_M1    = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  dmem_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  be_q;
  logic        we_q;
  logic        err_q;

  logic          accept;
  logic [31:0]   offset;
  logic          in_range;
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_rdata;

  // Request decode: legality of lanes and the address window.
  always_comb begin
    accept   = req_valid_i && req_ready_o;
    offset   = req_addr_i - BASE_ADDR;
    in_range = (req_addr_i >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
    req_err  = !be_addr_legal(req_be_i, req_addr_i[1:0]) || !in_range;
    word_idx = offset[AW+1:2];
  end

  jedro_1_dmem_ram #(
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (accept && req_we_i && !req_err),
    .re_i    (accept),
    .be_i    (req_be_i),
    .addr_i  (word_idx),
    .wdata_i (req_wdata_i),
    .rdata_o (ram_rdata)
  );

  // State, wait counter and the attributes of the accepted request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        be_q  <= req_be_i;
        we_q  <= req_we_i;
        err_q <= req_err;
      end
    end
  end

  // Next-state: accept -> (WAIT countdown) -> RESP -> IDLE once the LSU takes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low during reset; load data is masked to the enabled lanes.
  always_comb begin
    req_ready_o = (state_q == IDLE) && !rst_i;
    rsp_valid_o = (state_q == RESP) && !rst_i;
    rsp_err_o   = rsp_valid_o && err_q;
    rsp_rdata_o = (rsp_valid_o && !err_q && !we_q) ? (ram_rdata & be_mask(be_q)) : 32'd0;
  end

endmodule
